regfile_write_decoder: RTL and testbench

//  Multi-port register-file write decoder. Maps each write port's register address to a one-hot wordline.

---
 rtl/regfile_pkg.sv | 14 +
 rtl/onehot_decoder.sv | 17 +
 rtl/regfile_write_decoder.sv | 130 +++++++++++++
 tb/tb_regfile_write_decoder.sv | 259 +++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and address/port typedefs for the register-file write path.
package regfile_pkg;

  localparam int unsigned NUM_REGS_DEF   = 16;
  localparam int unsigned ADDR_W_DEF     = $clog2(NUM_REGS_DEF);
  localparam int unsigned NUM_PORTS_DEF  = 2;
  localparam int unsigned PSEL_W_DEF     = (NUM_PORTS_DEF > 1) ? $clog2(NUM_PORTS_DEF) : 1;
  localparam int unsigned CONFLICT_CNT_W = 16;

  typedef logic [ADDR_W_DEF-1:0]     reg_addr_t;
  typedef logic [PSEL_W_DEF-1:0]     port_idx_t;
  typedef logic [CONFLICT_CNT_W-1:0] conflict_cnt_t;

endpackage

// File: rtl/onehot_decoder.sv
// Binary register address to one-hot wordline request; all zero when disabled.
module onehot_decoder #(
  parameter  int unsigned ADDR_W  = 4,
  localparam int unsigned NUM_OUT = 1 << ADDR_W
) (
  input  logic [ADDR_W-1:0]  addr,
  input  logic               en,
  output logic [NUM_OUT-1:0] onehot
);

  // Single hot bit at the addressed position when enabled
  always_comb begin
    onehot = '0;
    if (en) onehot[addr] = 1'b1;
  end

endmodule

// File: rtl/regfile_write_decoder.sv
// Multi-port register-file write decoder: per-register round-robin pick among
// write ports, registered wordline / port select / done, rotating priority and
// a saturating conflict counter.
module regfile_write_decoder
  import regfile_pkg::*;
#(
  parameter  int unsigned NUM_REGS    = NUM_REGS_DEF,
  parameter  int unsigned NUM_PORTS   = NUM_PORTS_DEF,
  parameter  bit          ZERO_REG_RO = 1'b0,
  localparam int unsigned ADDR_W      = $clog2(NUM_REGS),
  localparam int unsigned PSEL_W      = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_PORTS-1:0]          wr_valid,
  input  logic [NUM_PORTS*ADDR_W-1:0]   wr_addr,
  output logic [NUM_PORTS-1:0]          wr_ready,
  output logic [NUM_REGS-1:0]           wordline,
  output logic [NUM_REGS*PSEL_W-1:0]    port_sel,
  output logic [NUM_PORTS-1:0]          wr_done,
  output logic [PSEL_W-1:0]             rr_ptr,
  output logic [CONFLICT_CNT_W-1:0]     conflict_cnt
);

  logic [NUM_REGS-1:0]       req_oh [NUM_PORTS];
  logic [PSEL_W-1:0]         win_port [NUM_REGS];
  logic [NUM_REGS-1:0]       win_hit;
  logic [NUM_REGS-1:0]       reg_conflict;
  logic                      conflict_any;
  logic [PSEL_W-1:0]         rr_ptr_d;
  logic [NUM_REGS-1:0]       wordline_d;
  logic [NUM_REGS*PSEL_W-1:0] port_sel_d;
  logic [CONFLICT_CNT_W-1:0] conflict_cnt_d;

  // One decoder per write port turns its request into a register one-hot
  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_dec
    onehot_decoder #(.ADDR_W(ADDR_W)) u_dec (
      .addr   (wr_addr[p*ADDR_W +: ADDR_W]),
      .en     (wr_valid[p]),
      .onehot (req_oh[p])
    );
  end

  // Per-register pick: first requester in rotating order from rr_ptr wins
  always_comb begin
    int unsigned idx;
    idx          = 0;
    win_port     = '{default: '0};
    win_hit      = '0;
    reg_conflict = '0;
    for (int unsigned a = 0; a < NUM_REGS; a++) begin
      for (int unsigned k = 0; k < NUM_PORTS; k++) begin
        idx = 32'(rr_ptr) + k;
        if (idx >= NUM_PORTS) idx = idx - NUM_PORTS;
        if (req_oh[PSEL_W'(idx)][ADDR_W'(a)]) begin
          if (win_hit[ADDR_W'(a)]) begin
            reg_conflict[ADDR_W'(a)] = 1'b1;
          end else begin
            win_hit[ADDR_W'(a)]  = 1'b1;
            win_port[ADDR_W'(a)] = PSEL_W'(idx);
          end
        end
      end
    end
  end

  // A port is ready when it is the winner for its own target register
  always_comb begin
    logic [ADDR_W-1:0] ap;
    ap       = '0;
    wr_ready = '0;
    for (int unsigned p = 0; p < NUM_PORTS; p++) begin
      ap = wr_addr[p*ADDR_W +: ADDR_W];
      wr_ready[p] = !reset && wr_valid[p] && win_hit[ap] && (win_port[ap] == PSEL_W'(p));
    end
  end

  // Rotate priority past the lowest-numbered port that won a contested register
  always_comb begin
    int unsigned min_win;
    min_win      = NUM_PORTS;
    conflict_any = |reg_conflict;
    for (int unsigned a = 0; a < NUM_REGS; a++) begin
      if (reg_conflict[ADDR_W'(a)] && (32'(win_port[ADDR_W'(a)]) < min_win)) begin
        min_win = 32'(win_port[ADDR_W'(a)]);
      end
    end
    if (!conflict_any)                rr_ptr_d = rr_ptr;
    else if (min_win + 1 >= NUM_PORTS) rr_ptr_d = '0;
    else                               rr_ptr_d = PSEL_W'(min_win + 1);
  end

  // Next wordline / port select; a read-only register 0 is never enabled
  always_comb begin
    wordline_d = '0;
    port_sel_d = '0;
    for (int unsigned a = 0; a < NUM_REGS; a++) begin
      if (win_hit[ADDR_W'(a)] && !(ZERO_REG_RO && (a == 0))) begin
        wordline_d[ADDR_W'(a)]          = 1'b1;
        port_sel_d[a*PSEL_W +: PSEL_W]  = win_port[ADDR_W'(a)];
      end
    end
  end

  // Conflict cycles counted with saturation at all-ones
  always_comb begin
    conflict_cnt_d = conflict_cnt;
    if (conflict_any && (conflict_cnt != '1)) begin
      conflict_cnt_d = conflict_cnt + CONFLICT_CNT_W'(1);
    end
  end

  // Output and arbitration state registers
  always_ff @(posedge clk) begin
    if (reset) begin
      wordline     <= '0;
      port_sel     <= '0;
      wr_done      <= '0;
      rr_ptr       <= '0;
      conflict_cnt <= '0;
    end else begin
      wordline     <= wordline_d;
      port_sel     <= port_sel_d;
      wr_done      <= wr_ready;
      rr_ptr       <= rr_ptr_d;
      conflict_cnt <= conflict_cnt_d;
    end
  end

endmodule

// File: tb/tb_regfile_write_decoder.sv
// Self-checking bench: directed vectors, a behavioural arbitration model checked
// every cycle, and literal expectations for the key scenarios.
module tb_regfile_write_decoder;

  localparam int NR = 16;
  localparam int NP = 2;
  localparam int AW = 4;
  localparam int PW = 1;

  logic              clk = 1'b0;
  logic              reset;
  logic [NP-1:0]     wr_valid;
  logic [NP*AW-1:0]  wr_addr;

  logic [NP-1:0]     wr_ready,  z_wr_ready;
  logic [NR-1:0]     wordline,  z_wordline;
  logic [NR*PW-1:0]  port_sel,  z_port_sel;
  logic [NP-1:0]     wr_done,   z_wr_done;
  logic [PW-1:0]     rr_ptr,    z_rr_ptr;
  logic [15:0]       conflict_cnt, z_conflict_cnt;

  int n_checks = 0;
  int n_err    = 0;

  // model state
  bit            started = 1'b0;
  logic [NR-1:0] m_wl;
  int            m_ps [NR];
  logic [NP-1:0] m_done;
  int            m_ptr;
  int            m_cnt;

  regfile_write_decoder #(.NUM_REGS(NR), .NUM_PORTS(NP), .ZERO_REG_RO(1'b0)) dut (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_ready(wr_ready), .wordline(wordline), .port_sel(port_sel),
    .wr_done(wr_done), .rr_ptr(rr_ptr), .conflict_cnt(conflict_cnt)
  );

  regfile_write_decoder #(.NUM_REGS(NR), .NUM_PORTS(NP), .ZERO_REG_RO(1'b1)) dut_z (
    .clk(clk), .reset(reset), .wr_valid(wr_valid), .wr_addr(wr_addr),
    .wr_ready(z_wr_ready), .wordline(z_wordline), .port_sel(z_port_sel),
    .wr_done(z_wr_done), .rr_ptr(z_rr_ptr), .conflict_cnt(z_conflict_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int addr_of(input logic [NP*AW-1:0] ad, input int p);
    return int'(ad[p*AW +: AW]);
  endfunction

  // Port p is granted iff valid and no valid same-address port precedes it in rotation
  function automatic logic [NP-1:0] model_ready(input logic [NP-1:0] v, input logic [NP*AW-1:0] ad,
                                                input int ptr, input logic rst);
    logic [NP-1:0] r;
    r = '0;
    for (int p = 0; p < NP; p++) begin
      if (v[p] && !rst) begin
        r[p] = 1'b1;
        for (int q = 0; q < NP; q++) begin
          if (q != p && v[q] && addr_of(ad, q) == addr_of(ad, p) &&
              ((q - ptr + NP) % NP) < ((p - ptr + NP) % NP)) r[p] = 1'b0;
        end
      end
    end
    return r;
  endfunction

  function automatic logic [NR*PW-1:0] pack_ps(input bit zero_ro);
    logic [NR*PW-1:0] v;
    v = '0;
    for (int a = 0; a < NR; a++) begin
      if (!(zero_ro && a == 0)) v[a*PW +: PW] = PW'(m_ps[a]);
    end
    return v;
  endfunction

  function automatic int ps_field(input logic [NR*PW-1:0] v, input int a);
    return int'(v[a*PW +: PW]);
  endfunction

  // Model update at each active edge
  always @(posedge clk) begin
    logic [NP-1:0] r;
    int  minw;
    bit  conf;
    if (reset) begin
      started = 1'b1;
      m_wl    = '0;
      for (int a = 0; a < NR; a++) m_ps[a] = 0;
      m_done  = '0;
      m_ptr   = 0;
      m_cnt   = 0;
    end else begin
      r    = model_ready(wr_valid, wr_addr, m_ptr, 1'b0);
      m_wl = '0;
      for (int a = 0; a < NR; a++) m_ps[a] = 0;
      for (int p = 0; p < NP; p++) begin
        if (r[p]) begin
          m_wl[addr_of(wr_addr, p)] = 1'b1;
          m_ps[addr_of(wr_addr, p)] = p;
        end
      end
      m_done = r;
      conf = 1'b0;
      minw = NP;
      for (int p = 0; p < NP; p++) begin
        for (int q = 0; q < NP; q++) begin
          if (p != q && wr_valid[p] && wr_valid[q] && addr_of(wr_addr, p) == addr_of(wr_addr, q)) begin
            conf = 1'b1;
            if (r[p] && p < minw) minw = p;
          end
        end
      end
      if (conf) begin
        m_ptr = (minw + 1) % NP;
        if (m_cnt < 65535) m_cnt++;
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("ready",      64'(wr_ready),       64'(model_ready(wr_valid, wr_addr, m_ptr, reset)));
      chk("z_ready",    64'(z_wr_ready),     64'(model_ready(wr_valid, wr_addr, m_ptr, reset)));
      chk("wordline",   64'(wordline),       64'(m_wl));
      chk("z_wordline", 64'(z_wordline),     64'(m_wl & ~NR'(1)));
      chk("port_sel",   64'(port_sel),       64'(pack_ps(1'b0)));
      chk("z_port_sel", 64'(z_port_sel),     64'(pack_ps(1'b1)));
      chk("wr_done",    64'(wr_done),        64'(m_done));
      chk("z_wr_done",  64'(z_wr_done),      64'(m_done));
      chk("rr_ptr",     64'(rr_ptr),         64'(m_ptr));
      chk("cnt",        64'(conflict_cnt),   64'(m_cnt));
      chk("z_cnt",      64'(z_conflict_cnt), 64'(m_cnt));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [NP-1:0] v, input int a0, input int a1);
    wr_valid = v;
    wr_addr  = {AW'(a1), AW'(a0)};
  endtask

  initial begin
    reset = 1'b1;
    drive(2'b00, 0, 0);
    tick();
    tick();
    chk("rst_wordline", 64'(wordline),     64'h0);
    chk("rst_port_sel", 64'(port_sel),     64'h0);
    chk("rst_done",     64'(wr_done),      64'h0);
    chk("rst_ptr",      64'(rr_ptr),       64'h0);
    chk("rst_cnt",      64'(conflict_cnt), 64'h0);
    reset = 1'b0;

    // single write, then idle clears it
    drive(2'b01, 3, 0); #1;
    chk("t1_ready", 64'(wr_ready), 64'h1);
    tick();
    chk("t1_wordline", 64'(wordline), 64'h0008);
    chk("t1_ps3",      64'(ps_field(port_sel, 3)), 64'h0);
    chk("t1_done",     64'(wr_done), 64'h1);
    drive(2'b00, 0, 0);
    tick();
    chk("t1_idle_wl", 64'(wordline), 64'h0);

    // two distinct addresses in one cycle
    drive(2'b11, 2, 9); #1;
    chk("t2_ready", 64'(wr_ready), 64'h3);
    tick();
    chk("t2_wordline", 64'(wordline), 64'h0204);
    chk("t2_ps9",      64'(ps_field(port_sel, 9)), 64'h1);
    chk("t2_ps2",      64'(ps_field(port_sel, 2)), 64'h0);
    chk("t2_cnt",      64'(conflict_cnt), 64'h0);
    drive(2'b00, 0, 0);
    tick();

    // conflict on 5 with rr_ptr=0, loser then granted
    drive(2'b11, 5, 5); #1;
    chk("t3_ready", 64'(wr_ready), 64'h1);
    tick();
    chk("t3_wordline", 64'(wordline), 64'h0020);
    chk("t3_ps5",      64'(ps_field(port_sel, 5)), 64'h0);
    chk("t3_ptr",      64'(rr_ptr), 64'h1);
    chk("t3_cnt",      64'(conflict_cnt), 64'h1);
    drive(2'b10, 5, 5); #1;
    chk("t3_held_ready", 64'(wr_ready), 64'h2);
    tick();
    chk("t3_held_ps5",  64'(ps_field(port_sel, 5)), 64'h1);
    chk("t3_held_done", 64'(wr_done), 64'h2);
    drive(2'b00, 0, 0);
    tick();

    // conflict on 7 with rr_ptr=1: port 1 wins, pointer wraps
    drive(2'b11, 7, 7); #1;
    chk("t4_ready", 64'(wr_ready), 64'h2);
    tick();
    chk("t4_wordline", 64'(wordline), 64'h0080);
    chk("t4_ps7",      64'(ps_field(port_sel, 7)), 64'h1);
    chk("t4_ptr",      64'(rr_ptr), 64'h0);
    chk("t4_cnt",      64'(conflict_cnt), 64'h2);
    drive(2'b00, 0, 0);
    tick();

    // write to register 0: read-only instance drops it
    drive(2'b01, 0, 0); #1;
    chk("t5_z_ready", 64'(z_wr_ready), 64'h1);
    tick();
    chk("t5_z_wordline", 64'(z_wordline), 64'h0);
    chk("t5_z_done",     64'(z_wr_done),  64'h1);
    chk("t5_wordline",   64'(wordline),   64'h0001);
    drive(2'b00, 0, 0);
    tick();

    // reset while requesting, then release with the same requests
    reset = 1'b1;
    drive(2'b11, 4, 6); #1;
    chk("t6_rst_ready", 64'(wr_ready), 64'h0);
    tick();
    chk("t6_rst_wl",   64'(wordline),     64'h0);
    chk("t6_rst_done", 64'(wr_done),      64'h0);
    chk("t6_rst_cnt",  64'(conflict_cnt), 64'h0);
    reset = 1'b0; #1;
    chk("t6_ready", 64'(wr_ready), 64'h3);
    tick();
    chk("t6_wordline", 64'(wordline), 64'h0050);
    chk("t6_done",     64'(wr_done),  64'h3);
    drive(2'b00, 0, 0);
    tick();

    // sustained conflicts up to saturation
    drive(2'b11, 7, 7);
    repeat (65534) tick();
    chk("sat_fffe", 64'(conflict_cnt), 64'hFFFE);
    tick();
    chk("sat_ffff", 64'(conflict_cnt), 64'hFFFF);
    tick();
    chk("sat_hold", 64'(conflict_cnt), 64'hFFFF);
    drive(2'b00, 0, 0);
    tick();
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
